// File: rtl/ioctl_pkg.sv
// Shared types and constants for the ioctl download loader.
package ioctl_pkg;

    localparam int IOCTL_ADDR_W = 25;

    localparam logic [7:0] IDX_ROM   = 8'h00;
    localparam logic [7:0] IDX_NVRAM = 8'h04;

    typedef enum logic [2:0] {
        IDLE,
        ARM,
        FETCH,
        STROBE,
        GAP,
        FINISH
    } state_e;

endpackage

// File: rtl/ioctl_loader_if.sv
// Byte stream plus ioctl download bus between harness, loader and core top.
interface ioctl_loader_if
    import ioctl_pkg::*;
#(
    parameter int ADDR_W = IOCTL_ADDR_W
);
    logic              s_valid;
    logic [7:0]        s_data;
    logic              s_ready;
    logic              ioctl_download;
    logic [7:0]        ioctl_index;
    logic              ioctl_wr;
    logic [ADDR_W-1:0] ioctl_addr;
    logic [7:0]        ioctl_dout;
    logic              ioctl_wait;

    modport master (
        input  s_valid, s_data, ioctl_wait,
        output s_ready, ioctl_download, ioctl_index,
        output ioctl_wr, ioctl_addr, ioctl_dout
    );

    modport slave (
        output s_valid, s_data, ioctl_wait,
        input  s_ready, ioctl_download, ioctl_index,
        input  ioctl_wr, ioctl_addr, ioctl_dout
    );

endinterface

// File: rtl/ioctl_loader.sv
// Replays a valid/ready byte stream as a MiSTer ioctl download.
// Define IOCTL_LOADER_CHECKSUM_EN to build the running byte-sum accumulator.
module ioctl_loader
    import ioctl_pkg::*;
#(
    parameter int ADDR_W = IOCTL_ADDR_W,
    parameter int WR_GAP = 4
) (
    input  logic              clk_sys,
    input  logic              reset,
    input  logic              start,
    input  logic [7:0]        index,
    input  logic [ADDR_W-1:0] length,
    ioctl_loader_if.master    bus,
    output logic              busy,
    output logic              done,
    output logic [7:0]        checksum
);

    localparam logic [3:0] GAP_LOAD = 4'(WR_GAP - 1);

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [ADDR_W-1:0] rem_q, rem_d;
    logic [7:0]        idx_q, idx_d;
    logic [7:0]        dout_q, dout_d;
    logic [3:0]        gap_q, gap_d;
    logic              zdone_q, zdone_d;

    logic start_ok;
    logic hs;

    assign start_ok = start & (state_q == IDLE);
    assign hs = (state_q == FETCH) & bus.s_valid & ~bus.ioctl_wait;

    always_ff @(posedge clk_sys or posedge reset) begin
        if (reset) state_q <= IDLE;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (start && length != '0) state_d = ARM;
            ARM:     state_d = FETCH;
            FETCH:   if (hs) state_d = STROBE;
            STROBE:  state_d = GAP;
            GAP: begin
                if (gap_q == '0)
                    state_d = (rem_q == '0) ? FINISH : FETCH;
            end
            FINISH:  state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        addr_d  = addr_q;
        rem_d   = rem_q;
        idx_d   = idx_q;
        dout_d  = dout_q;
        gap_d   = gap_q;
        zdone_d = start_ok && length == '0;
        if (start_ok && length != '0) begin
            idx_d  = index;
            rem_d  = length;
            addr_d = '0;
        end
        if (hs) dout_d = bus.s_data;
        if (state_q == STROBE) begin
            rem_d  = rem_q - 1'b1;
            addr_d = addr_q + 1'b1;
            gap_d  = GAP_LOAD;
        end
        if (state_q == GAP && gap_q != '0) gap_d = gap_q - 1'b1;
    end

    always_ff @(posedge clk_sys or posedge reset) begin
        if (reset) begin
            addr_q  <= '0;
            rem_q   <= '0;
            idx_q   <= '0;
            dout_q  <= '0;
            gap_q   <= '0;
            zdone_q <= 1'b0;
        end else begin
            addr_q  <= addr_d;
            rem_q   <= rem_d;
            idx_q   <= idx_d;
            dout_q  <= dout_d;
            gap_q   <= gap_d;
            zdone_q <= zdone_d;
        end
    end

    // Strobes and download are decoded from state so reset drops them at once.
    logic dl, wr, rdy;

    always_comb begin
        dl   = 1'b0;
        wr   = 1'b0;
        rdy  = 1'b0;
        busy = state_q != IDLE;
        done = zdone_q;
        unique case (state_q)
            ARM:     dl = 1'b1;
            FETCH: begin
                dl  = 1'b1;
                rdy = ~bus.ioctl_wait;
            end
            STROBE: begin
                dl = 1'b1;
                wr = 1'b1;
            end
            GAP:     dl = 1'b1;
            FINISH:  done = 1'b1;
            default: ;
        endcase
    end

    assign bus.s_ready        = rdy;
    assign bus.ioctl_download = dl;
    assign bus.ioctl_wr       = wr;
    assign bus.ioctl_index    = idx_q;
    assign bus.ioctl_addr     = addr_q;
    assign bus.ioctl_dout     = dout_q;

`ifdef IOCTL_LOADER_CHECKSUM_EN
    logic [7:0] sum_q, sum_d;

    always_comb begin
        sum_d = sum_q;
        if (start_ok)  sum_d = '0;
        else if (hs)   sum_d = sum_q + bus.s_data;
    end

    always_ff @(posedge clk_sys or posedge reset) begin
        if (reset) sum_q <= '0;
        else       sum_q <= sum_d;
    end

    assign checksum = sum_q;
`else
    assign checksum = 8'h00;
`endif

endmodule
